// File: rtl/ssd_pkg.sv
// Shared types and segment table for the seven-segment scan controller.
// Segment bit order: seg[0]=a .. seg[6]=g, active-high.
package ssd_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_BLANK
    } state_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SA = 7'(1) << SEG_A;
    localparam logic [6:0] SB = 7'(1) << SEG_B;
    localparam logic [6:0] SC = 7'(1) << SEG_C;
    localparam logic [6:0] SD = 7'(1) << SEG_D;
    localparam logic [6:0] SE = 7'(1) << SEG_E;
    localparam logic [6:0] SF = 7'(1) << SEG_F;
    localparam logic [6:0] SG = 7'(1) << SEG_G;

    // 0-9, A, b, C, d, E, F
    localparam logic [6:0] SEG_TABLE [16] = '{
        SA | SB | SC | SD | SE | SF,
        SB | SC,
        SA | SB | SD | SE | SG,
        SA | SB | SC | SD | SG,
        SB | SC | SF | SG,
        SA | SC | SD | SF | SG,
        SA | SC | SD | SE | SF | SG,
        SA | SB | SC,
        SA | SB | SC | SD | SE | SF | SG,
        SA | SB | SC | SD | SF | SG,
        SA | SB | SC | SE | SF | SG,
        SC | SD | SE | SF | SG,
        SA | SD | SE | SF,
        SB | SC | SD | SE | SG,
        SA | SD | SE | SF | SG,
        SA | SE | SF | SG
    };

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational hex nibble to 7-segment decoder.
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with double-buffered load.
// Optional: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 kept).
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int ms_limit     = 100000,
    parameter int DIGIT_MS     = 1,
    parameter int BLANK_CYCLES = 2,
    parameter int N_DIGITS     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*N_DIGITS-1:0]   load_data,
    input  logic [N_DIGITS-1:0]     load_dp,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_done
);

    localparam int MW   = ms_limit > 1 ? $clog2(ms_limit) : 1;
    localparam int TW   = DIGIT_MS > 1 ? $clog2(DIGIT_MS) : 1;
    localparam int BW   = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
    localparam int IW   = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam int BMAX = BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0;

    localparam logic [MW-1:0] MS_MAX  = MW'(ms_limit - 1);
    localparam logic [TW-1:0] TK_MAX  = TW'(DIGIT_MS - 1);
    localparam logic [BW-1:0] BK_MAX  = BW'(BMAX);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE = N_DIGITS'(1);

    state_t                 state_q, state_n;
    logic [IW-1:0]          idx_q, idx_n, idx_inc;
    logic [MW-1:0]          ms_q, ms_n;
    logic [TW-1:0]          tick_q, tick_n;
    logic [BW-1:0]          blk_q, blk_n;
    logic [4*N_DIGITS-1:0]  act_d_q, act_d_n, pend_d_q, pend_d_n;
    logic [N_DIGITS-1:0]    act_p_q, act_p_n, pend_p_q, pend_p_n;
    logic                   pend_q, pend_n, ready_q;
    logic [6:0]             seg_q, seg_n, dec_seg;
    logic                   dp_q, dp_n, fd_q, fd_n;
    logic [N_DIGITS-1:0]    an_q, an_n;
    logic                   bnd, last, dwell_end, show, xfer, copy, lz;
    logic [3:0]             nib;

    always_comb begin
        state_n   = state_q;
        idx_n     = idx_q;
        ms_n      = ms_q;
        tick_n    = tick_q;
        blk_n     = blk_q;
        bnd       = 1'b0;
        dwell_end = (ms_q == MS_MAX) && (tick_q == TK_MAX);
        last      = (idx_q == IDX_MAX);
        idx_inc   = last ? '0 : idx_q + 1'b1;
        if (!enable) begin
            state_n = S_IDLE;
            idx_n   = '0;
            ms_n    = '0;
            tick_n  = '0;
            blk_n   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_n = S_SHOW;
                    idx_n   = '0;
                    ms_n    = '0;
                    tick_n  = '0;
                    bnd     = 1'b1;
                end
                S_SHOW: begin
                    if (!dwell_end) begin
                        if (ms_q == MS_MAX) begin
                            ms_n   = '0;
                            tick_n = tick_q + 1'b1;
                        end else begin
                            ms_n = ms_q + 1'b1;
                        end
                    end else if (BLANK_CYCLES == 0) begin
                        idx_n  = idx_inc;
                        ms_n   = '0;
                        tick_n = '0;
                        bnd    = last;
                    end else begin
                        state_n = S_BLANK;
                        blk_n   = '0;
                    end
                end
                S_BLANK: begin
                    if (blk_q == BK_MAX) begin
                        state_n = S_SHOW;
                        idx_n   = idx_inc;
                        ms_n    = '0;
                        tick_n  = '0;
                        bnd     = last;
                    end else begin
                        blk_n = blk_q + 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // A boundary copy wins; a same-cycle transfer waits for the next one.
    always_comb begin
        xfer     = load_valid && ready_q;
        copy     = bnd && pend_q;
        act_d_n  = copy ? pend_d_q : act_d_q;
        act_p_n  = copy ? pend_p_q : act_p_q;
        pend_d_n = pend_d_q;
        pend_p_n = pend_p_q;
        pend_n   = pend_q;
        if (copy) begin
            pend_n = 1'b0;
        end else if (xfer) begin
            pend_n   = 1'b1;
            pend_d_n = load_data;
            pend_p_n = load_dp;
        end
    end

    assign nib = act_d_n[int'(idx_n)*4 +: 4];

    ssd_hex_decode u_dec (
        .nibble (nib),
        .seg    (dec_seg)
    );

    always_comb begin
        lz = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        lz = (idx_n != '0);
        for (int k = 0; k < N_DIGITS; k++) begin
            if (k >= int'(idx_n) && act_d_n[k*4 +: 4] != 4'h0) lz = 1'b0;
        end
`endif
        show = (state_n == S_SHOW);
        an_n = show ? (AN_ONE << idx_n) : '0;
        seg_n = (show && !lz) ? dec_seg : 7'h00;
        dp_n = show && act_p_n[idx_n];
        if (BLANK_CYCLES == 0)
            fd_n = show && (idx_n == IDX_MAX) &&
                   (ms_n == MS_MAX) && (tick_n == TK_MAX);
        else
            fd_n = (state_n == S_BLANK) && (blk_n == BK_MAX) &&
                   (idx_n == IDX_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            ms_q     <= '0;
            tick_q   <= '0;
            blk_q    <= '0;
            act_d_q  <= '0;
            act_p_q  <= '0;
            pend_d_q <= '0;
            pend_p_q <= '0;
            pend_q   <= 1'b0;
            ready_q  <= 1'b0;
            seg_q    <= '0;
            dp_q     <= 1'b0;
            an_q     <= '0;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_n;
            idx_q    <= idx_n;
            ms_q     <= ms_n;
            tick_q   <= tick_n;
            blk_q    <= blk_n;
            act_d_q  <= act_d_n;
            act_p_q  <= act_p_n;
            pend_d_q <= pend_d_n;
            pend_p_q <= pend_p_n;
            pend_q   <= pend_n;
            ready_q  <= !pend_n;
            seg_q    <= seg_n;
            dp_q     <= dp_n;
            an_q     <= an_n;
            fd_q     <= fd_n;
        end
    end

    assign load_ready = ready_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl (ms_limit=3, DIGIT_MS=1, BLANK_CYCLES=1).
// A 16-cycle frame model tracks the expected outputs cycle by cycle.
module tb_ssd_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  load_dp;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int fails  = 0;

    ssd_scan_ctrl #(
        .ms_limit     (3),
        .DIGIT_MS     (1),
        .BLANK_CYCLES (1),
        .N_DIGITS     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written segment codes, bit0 = a
    logic [6:0] hex7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic [15:0] m_act, m_pdata;
    logic [3:0]  m_adp, m_pdp;
    logic        m_pend, m_ready, m_run, m_xfer;
    int          m_pos;

    task automatic step();
        logic x, b;
        @(posedge clk);
        x = load_valid && m_ready;
        b = enable && (!m_run || m_pos == 15);
        if (rst) begin
            m_act = '0; m_adp = '0; m_pend = 1'b0;
            m_run = 1'b0; m_pos = 0; m_ready = 1'b0;
            m_xfer = 1'b0;
        end else begin
            m_xfer = 1'b0;
            if (b && m_pend) begin
                m_act = m_pdata; m_adp = m_pdp; m_pend = 1'b0;
            end else if (x) begin
                m_pdata = load_data; m_pdp = load_dp;
                m_pend = 1'b1; m_xfer = 1'b1;
            end
            m_pos   = (!enable || !m_run) ? 0 : (m_pos + 1) % 16;
            m_run   = enable;
            m_ready = !m_pend;
        end
        #1;
    endtask

    function automatic logic [13:0] e_vec();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] n;
        int         d;
        e_an = 4'b0; e_seg = 7'h00; e_dp = 1'b0;
        d = m_pos / 4;
        if (m_run && (m_pos % 4) != 3) begin
            e_an  = 4'b0001 << d;
            n     = m_act[d*4 +: 4];
            e_seg = hex7[n];
            e_dp  = m_adp[d];
`ifdef LEADING_ZERO_BLANK_EN
            if (d > 0 && (m_act >> (d*4)) == 16'h0) e_seg = 7'h00;
`endif
        end
        return {e_an, e_seg, e_dp, m_run && m_pos == 15, m_ready};
    endfunction

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; load_valid = 1'b0;
        load_data = '0; load_dp = '0;
        step(); step();
        checks++;
        if ({an, seg, dp, frame_done, load_ready} !== 14'h0) begin
            fails++;
            $display("FAIL reset_outs got %h exp 0",
                     {an, seg, dp, frame_done, load_ready});
        end
        rst = 1'b0;
        step();
        checks++;
        if (load_ready !== 1'b1 || an !== 4'b0) begin
            fails++;
            $display("FAIL reset_release ready=%b an=%b exp 1/0000",
                     load_ready, an);
        end
    endtask

    task automatic test_scan();
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_done, load_ready} !== e_vec()) begin
                fails++;
                $display("FAIL scan pos=%0d got %h exp %h", m_pos,
                         {an, seg, dp, frame_done, load_ready}, e_vec());
            end
        end
        checks++;
        if (frame_done !== 1'b1 || an !== 4'b0000) begin
            fails++;
            $display("FAIL scan_fd fd=%b an=%b exp 1/0000", frame_done, an);
        end
    endtask

    task automatic test_load();
        int n;
        n = 0;
        while (m_pos != 5 && n < 40) begin step(); n++; end
        load_valid = 1'b1; load_data = 16'h12AF; load_dp = 4'b0100;
        step();
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0 || seg !== 7'h3F) begin
            fails++;
            $display("FAIL load_accept ready=%b seg=%h exp 0/3f",
                     load_ready, seg);
        end
        load_valid = 1'b1; load_data = 16'h3456; load_dp = 4'b0001;
        n = 0;
        do begin
            step(); n++;
            checks++;
            if ({an, seg, dp, frame_done, load_ready} !== e_vec()) begin
                fails++;
                $display("FAIL load_hold pos=%0d got %h exp %h", m_pos,
                         {an, seg, dp, frame_done, load_ready}, e_vec());
            end
            if (m_pos == 0 && m_run) begin
                checks++;
                if (seg !== 7'h71 || load_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL load_boundary seg=%h ready=%b exp 71/1",
                             seg, load_ready);
                end
            end
        end while (!m_xfer && n < 40);
        load_valid = 1'b0;
        checks++;
        if (!m_xfer || load_ready !== 1'b0) begin
            fails++;
            $display("FAIL load_second xfer=%b ready=%b exp 1/0",
                     m_xfer, load_ready);
        end
        n = 0;
        while (m_pos != 8 && n < 40) begin
            step(); n++;
            checks++;
            if ({an, seg, dp, frame_done, load_ready} !== e_vec()) begin
                fails++;
                $display("FAIL load_frame pos=%0d got %h exp %h", m_pos,
                         {an, seg, dp, frame_done, load_ready}, e_vec());
            end
        end
        checks++;
        if (an !== 4'b0100 || seg !== 7'h5B || dp !== 1'b1) begin
            fails++;
            $display("FAIL load_digit2 an=%b seg=%h dp=%b exp 0100/5b/1",
                     an, seg, dp);
        end
    endtask

    task automatic test_enable_drop();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_done, load_ready} !== 14'h0) begin
                fails++;
                $display("FAIL idle_dark cyc=%0d got %h exp 0", i,
                         {an, seg, dp, frame_done, load_ready});
            end
        end
        enable = 1'b1;
        step();
        checks++;
        if (an !== 4'b0001 || seg !== 7'h7D || dp !== 1'b1) begin
            fails++;
            $display("FAIL reenable an=%b seg=%h dp=%b exp 0001/7d/1",
                     an, seg, dp);
        end
        for (int i = 0; i < 15; i++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_done, load_ready} !== e_vec()) begin
                fails++;
                $display("FAIL reenable_frame pos=%0d got %h exp %h", m_pos,
                         {an, seg, dp, frame_done, load_ready}, e_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (m_pos != 3 && n < 40) begin step(); n++; end
        rst = 1'b1;
        step();
        checks++;
        if ({an, seg, dp, frame_done, load_ready} !== 14'h0) begin
            fails++;
            $display("FAIL rst_mid got %h exp 0",
                     {an, seg, dp, frame_done, load_ready});
        end
        enable = 1'b0;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (load_ready !== 1'b1 || an !== 4'b0) begin
            fails++;
            $display("FAIL rst_mid_release ready=%b an=%b exp 1/0000",
                     load_ready, an);
        end
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_done, load_ready} !== e_vec()) begin
                fails++;
                $display("FAIL rst_active0 pos=%0d got %h exp %h", m_pos,
                         {an, seg, dp, frame_done, load_ready}, e_vec());
            end
        end
        checks++;
        if (an !== 4'b0000 || seg !== 7'h00) begin
            fails++;
            $display("FAIL rst_blank an=%b seg=%h exp 0000/00", an, seg);
        end
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    task automatic test_lzb();
        load_valid = 1'b1; load_data = 16'h0070; load_dp = 4'b0000;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_done, load_ready} !== e_vec()) begin
                fails++;
                $display("FAIL lzb pos=%0d got %h exp %h", m_pos,
                         {an, seg, dp, frame_done, load_ready}, e_vec());
            end
            if (m_act == 16'h0070 && m_pos == 12) begin
                checks++;
                if (an !== 4'b1000 || seg !== 7'h00) begin
                    fails++;
                    $display("FAIL lzb_d3 an=%b seg=%h exp 1000/00", an, seg);
                end
            end
        end
    endtask
`endif

    initial begin
        m_act = '0; m_adp = '0; m_pdata = '0; m_pdp = '0;
        m_pend = 1'b0; m_ready = 1'b0; m_run = 1'b0;
        m_xfer = 1'b0; m_pos = 0;
        test_reset();
        test_scan();
        test_load();
        test_enable_drop();
        test_reset_mid();
`ifdef LEADING_ZERO_BLANK_EN
        test_lzb();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
